// File: rtl/alu_seq.sv
// Registered 16-op ALU with multi-cycle shift-add multiply and restoring square root.
// Results and flags update only on done; out drives a tri-state bus under eo.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       mode,
  input  logic             ee,
  input  logic             eo,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_ovf
);

  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB;
  localparam logic [3:0] OP_NOT = 4'hC, OP_MLO = 4'hD, OP_MHI = 4'hE, OP_SQRT = 4'hF;

  localparam logic [WIDTH-1:0] W_LIM    = WIDTH[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W    = 1;
  localparam logic [WIDTH:0]   ONE_X    = 1;
  localparam logic [CW-1:0]    CNT_ONE  = 1;
  localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    SQ_LAST  = CW'(HW - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SQRT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] a_q, p_hi, p_lo, x_q;
  logic [RW-1:0]    rem;
  logic [HW-1:0]    root;
  logic             hi_sel;

  logic [WIDTH-1:0] sc_res, b_op;
  logic             sc_carry, sc_ovf, cin;
  logic [WIDTH:0]   sum, shl_w, shr_w;

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    b_op     = (mode == OP_SUB) ? ~in_b : in_b;
    cin      = (mode == OP_ADD) ? 1'b0 : flag_carry;
    sum      = {1'b0, in_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    shl_w    = {1'b0, in_a} << in_b;
    shr_w    = {in_a, 1'b0} >> in_b;
    case (mode)
      OP_ADD, OP_ADC, OP_SUB: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (in_a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_INC: {sc_carry, sc_res} = {1'b0, in_a} + ONE_X;
      OP_DEC: begin
        sc_res   = in_a - ONE_W;
        sc_carry = (in_a == '0);
      end
      OP_AND: sc_res = in_a & in_b;
      OP_OR:  sc_res = in_a | in_b;
      OP_XOR: sc_res = in_a ^ in_b;
      // A zero shift leaves nothing in the carry position, so carry is 0 naturally.
      OP_SHL: if (in_b < W_LIM) {sc_carry, sc_res} = shl_w;
      OP_SHR: if (in_b < W_LIM) {sc_res, sc_carry} = shr_w;
      OP_ROL: begin
        sc_res   = {in_a[WIDTH-2:0], in_a[WIDTH-1]};
        sc_carry = in_a[WIDTH-1];
      end
      OP_ROR: begin
        sc_res   = {in_a[0], in_a[WIDTH-1:1]};
        sc_carry = in_a[0];
      end
      OP_NOT: sc_res = ~in_a;
      default: ;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, mul_res;
  logic [RW-1:0]    rem_sh, trial, rem_nx;
  logic [HW-1:0]    root_nx;
  logic             sq_ge;

  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], p_lo[WIDTH-1:1]};
    mul_res   = hi_sel ? mul_hi_nx : mul_lo_nx;
    rem_sh    = (rem << 2) | {{(RW-2){1'b0}}, x_q[WIDTH-1 -: 2]};
    trial     = {root, 2'b01};
    sq_ge     = (rem_sh >= trial);
    rem_nx    = sq_ge ? (rem_sh - trial) : rem_sh;
    root_nx   = (root << 1) | {{(HW-1){1'b0}}, sq_ge};
  end

  // Operand capture and iteration registers; only meaningful while an op runs.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && ee) begin
      a_q    <= in_a;
      p_hi   <= '0;
      p_lo   <= in_b;
      x_q    <= in_a;
      rem    <= '0;
      root   <= '0;
      hi_sel <= (mode == OP_MHI);
    end else if (state == S_MUL) begin
      p_hi <= mul_hi_nx;
      p_lo <= mul_lo_nx;
    end else if (state == S_SQRT) begin
      rem  <= rem_nx;
      root <= root_nx;
      x_q  <= x_q << 2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (ee) begin
          cnt <= '0;
          if (mode == OP_MLO || mode == OP_MHI) begin
            state <= S_MUL;
            busy  <= 1'b1;
          end else if (mode == OP_SQRT) begin
            state <= S_SQRT;
            busy  <= 1'b1;
          end else begin
            result     <= sc_res;
            flag_zero  <= (sc_res == '0);
            flag_carry <= sc_carry;
            flag_neg   <= sc_res[WIDTH-1];
            flag_ovf   <= sc_ovf;
            done       <= 1'b1;
          end
        end
        S_MUL: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == MUL_LAST) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            result     <= mul_res;
            flag_zero  <= (mul_res == '0);
            flag_carry <= |mul_hi_nx;
            flag_neg   <= mul_res[WIDTH-1];
            flag_ovf   <= 1'b0;
          end
        end
        S_SQRT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == SQ_LAST) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            result     <= {{(WIDTH-HW){1'b0}}, root_nx};
            flag_zero  <= (root_nx == '0);
            flag_carry <= 1'b0;
            flag_neg   <= 1'b0;
            flag_ovf   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out = eo ? result : 'z;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural model predicts each result at issue,
// and the monitor compares on every done pulse.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ee, eo;
  logic [W-1:0] in_a, in_b;
  logic [3:0]   mode;
  wire  [W-1:0] out;
  logic         busy, done, flag_zero, flag_carry, flag_neg, flag_ovf;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .mode(mode),
    .ee(ee), .eo(eo), .out(out), .busy(busy), .done(done),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_neg(flag_neg), .flag_ovf(flag_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z, c, n, v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic m_carry;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sext(input int v);
    return (v >= (1 << (W-1))) ? v - (1 << W) : v;
  endfunction

  function automatic exp_t model(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    int ai, bi, full, ss, p, r, mask;
    exp_t e;
    logic [W-1:0] res;
    logic co, ov;
    ai = int'(a); bi = int'(b); mask = (1 << W) - 1;
    res = '0; co = 1'b0; ov = 1'b0;
    case (m)
      4'h0, 4'h1, 4'h2: begin
        full = ai + ((m == 4'h2) ? (mask - bi) : bi) + ((m == 4'h0) ? 0 : int'(c));
        res  = W'(full);
        co   = (full > mask);
        if (m == 4'h2) ss = sext(ai) - sext(bi) - 1 + int'(c);
        else           ss = sext(ai) + sext(bi) + ((m == 4'h1) ? int'(c) : 0);
        ov   = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
      end
      4'h3: begin full = ai + 1; res = W'(full); co = (full > mask); end
      4'h4: begin res = W'(ai - 1); co = (ai == 0); end
      4'h5: res = a & b;
      4'h6: res = a | b;
      4'h7: res = a ^ b;
      4'h8: if (bi == 0) res = a;
            else if (bi < W) begin res = W'(ai << bi); co = ((ai >> (W - bi)) & 1) != 0; end
      4'h9: if (bi == 0) res = a;
            else if (bi < W) begin res = W'(ai >> bi); co = ((ai >> (bi - 1)) & 1) != 0; end
      4'hA: begin res = W'((ai << 1) | (ai >> (W-1))); co = ((ai >> (W-1)) & 1) != 0; end
      4'hB: begin res = W'((ai >> 1) | ((ai & 1) << (W-1))); co = (ai & 1) != 0; end
      4'hC: res = ~a;
      4'hD, 4'hE: begin
        p   = ai * bi;
        res = (m == 4'hD) ? W'(p) : W'(p >> W);
        co  = (p >> W) != 0;
      end
      default: begin
        r = 0;
        while ((r + 1) * (r + 1) <= ai) r++;
        res = W'(r);
      end
    endcase
    e.res = res; e.z = (res == '0); e.c = co; e.n = res[W-1]; e.v = ov;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) check_val("spurious_done", 1, 0);
      else begin
        e = sb_q.pop_front();
        if (eo) check_val("out", out, e.res);
        check_val("flag_zero", flag_zero, e.z);
        check_val("flag_carry", flag_carry, e.c);
        check_val("flag_neg", flag_neg, e.n);
        check_val("flag_ovf", flag_ovf, e.v);
      end
    end
  end

  task automatic issue(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    in_a = a; in_b = b; mode = m; ee = 1'b1;
    e = model(m, a, b, m_carry);
    sb_q.push_back(e);
    m_carry = e.c;
  endtask

  // Called at a negedge; returns at a negedge with the op retired.
  task automatic do_op(input logic [3:0] m, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    int lat, bcnt, exp_lat;
    bit seen;
    exp_lat = (m == 4'hD || m == 4'hE) ? W + 1 : (m == 4'hF) ? W / 2 + 1 : 1;
    issue(m, a, b);
    @(negedge clk);
    ee = 1'b0; in_a = W'($urandom); in_b = W'($urandom); mode = 4'($urandom);
    lat = 1; bcnt = 0; seen = 0;
    while (!seen && lat <= 40) begin
      if (done) seen = 1;
      else begin
        if (busy) bcnt++;
        ee = (poke && bcnt == 3);
        if (ee) begin mode = 4'h0; in_a = 8'h11; in_b = 8'h22; end
        @(negedge clk);
        lat++;
      end
    end
    ee = 1'b0;
    if (!seen) check_val("done_timeout", 0, 1);
    else begin
      check_val("latency", lat, exp_lat);
      check_val("busy_cycles", bcnt, exp_lat - 1);
      @(negedge clk);
      check_val("done_pulse", done, 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_out"}, out, 0);
    check_val({tag, "_flags"}, {flag_zero, flag_carry, flag_neg, flag_ovf}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ee = 1'b0; eo = 1'b1; in_a = '0; in_b = '0; mode = '0; m_carry = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'h0, 8'hF0, 8'h20, 0);
    do_op(4'h1, 8'h01, 8'h01, 0);
    do_op(4'h0, 8'h7F, 8'h01, 0);
    do_op(4'h0, 8'hFF, 8'h01, 0);
    do_op(4'h2, 8'h05, 8'h05, 0);
    do_op(4'h2, 8'h03, 8'h05, 0);
    do_op(4'h0, 8'h80, 8'h80, 0);
    do_op(4'h3, 8'hFF, 8'h00, 0);
    do_op(4'h4, 8'h00, 8'h00, 0);
    do_op(4'hD, 8'hFF, 8'hFF, 0);
    do_op(4'hE, 8'hFF, 8'hFF, 1);
    do_op(4'hD, 8'h0F, 8'h03, 0);
    do_op(4'hF, 8'hC8, 8'h00, 0);
    do_op(4'hF, 8'h00, 8'h00, 0);
    do_op(4'hF, 8'hFF, 8'h00, 0);
    do_op(4'h8, 8'h81, 8'h01, 0);
    do_op(4'h9, 8'h81, 8'h08, 0);
    do_op(4'h8, 8'h81, 8'h00, 0);
    do_op(4'h9, 8'h81, 8'h07, 0);
    do_op(4'hB, 8'h01, 8'h00, 0);
    do_op(4'hA, 8'h80, 8'h00, 0);
    do_op(4'h5, 8'hCC, 8'hAA, 0);
    do_op(4'h6, 8'hCC, 8'hAA, 0);
    do_op(4'h7, 8'hCC, 8'hCC, 0);
    do_op(4'hC, 8'h0F, 8'h00, 0);

    // Back-to-back single-cycle ops: ee held high for consecutive edges.
    for (int i = 0; i < 8; i++) begin
      issue(4'($urandom_range(0, 12)), W'($urandom), W'($urandom_range(0, 9)));
      @(negedge clk);
    end
    ee = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      eo = (i % 10 != 7);
      do_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end
    eo = 1'b1;

    // Abort a multiply with reset part-way through.
    do_op(4'hD, 8'hFF, 8'hFF, 0);
    in_a = 8'h12; in_b = 8'h34; mode = 4'hD; ee = 1'b1;
    @(negedge clk);
    ee = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    sb_q.delete();
    m_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_cleared("post_abort");
    do_op(4'h0, 8'h01, 8'h01, 0);

    check_val("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
